// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller and its hex decoder.
// Segment patterns are abcdefg, active-low; SEG_OFF blanks all seven segments and the decimal point.
package ssd_scan_ctrl_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  // A single-digit display still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
// Kept standalone so that other score displays can reuse it.
module ssd_hex_decoder
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF[7:1];
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF[7:1];
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaler, digit counter, per-frame shadow
// registers, leading-zero blanking, PWM brightness and registered active-low outputs.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BRIGHT_BITS   = 4
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [7:0]              Cath,
  output logic                    frame_start
);

  localparam int                IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] cnt_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic                     tick;
  logic                     frame_wrap;

  logic [4*NUM_DIGITS-1:0]  nib_s_reg;
  logic [NUM_DIGITS-1:0]    dp_s_reg;
  logic [NUM_DIGITS-1:0]    en_s_reg;
  logic                     lz_s_reg;
  logic [BRIGHT_BITS-1:0]   bright_s_reg;

  logic [NUM_DIGITS-1:0]    blank_vec;
  logic [3:0]               cur_nib;
  seg_t                     cur_seg;
  logic                     pwm_on;
  logic                     lit;
  logic [NUM_DIGITS-1:0]    an_next;
  logic [7:0]               cath_next;

  logic [NUM_DIGITS-1:0]    an_reg;
  logic [7:0]               cath_reg;
  logic                     frame_start_reg;

  assign tick       = &cnt_reg;
  assign frame_wrap = tick && (idx_reg == LAST_IDX);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      if (tick) begin
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // Inputs are sampled only at the frame boundary so a digit never changes mid-scan.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      nib_s_reg    <= '0;
      dp_s_reg     <= '0;
      en_s_reg     <= '0;
      lz_s_reg     <= 1'b0;
      bright_s_reg <= '0;
    end else if (frame_wrap) begin
      nib_s_reg    <= value;
      dp_s_reg     <= dp_in;
      en_s_reg     <= digit_en;
      lz_s_reg     <= lz_blank;
      bright_s_reg <= brightness;
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_rightmost
      assign blank_vec[gi] = ~en_s_reg[gi];
    end else begin : g_upper
      assign blank_vec[gi] = ~en_s_reg[gi] |
                             (lz_s_reg & (nib_s_reg[4*NUM_DIGITS-1:4*gi] == '0));
    end
  end

  assign cur_nib = nib_s_reg[{idx_reg, 2'b00} +: 4];

  ssd_hex_decoder u_hex_decoder (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  assign pwm_on = (cnt_reg[SCAN_DIV_BITS-1 -: BRIGHT_BITS] < bright_s_reg);
  assign lit    = pwm_on && !blank_vec[idx_reg];

  always_comb begin
    an_next   = '1;
    cath_next = SEG_OFF;
    if (lit) begin
      an_next   = ~(NUM_DIGITS'(1) << idx_reg);
      cath_next = {cur_seg, ~dp_s_reg[idx_reg]};
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      an_reg          <= '1;
      cath_reg        <= SEG_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      an_reg          <= an_next;
      cath_reg        <= cath_next;
      frame_start_reg <= frame_wrap;
    end
  end

  assign An          = an_reg;
  assign Cath        = cath_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with 4 digits, 16-clock slots and 2-bit brightness.
// Expected cathode patterns per digit are hand-computed from the segment table.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  cath;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  ssd_scan_ctrl #(
    .NUM_DIGITS    (4),
    .SCAN_DIV_BITS (4),
    .BRIGHT_BITS   (2)
  ) dut (
    .ClkPort     (clk),
    .Reset       (rst),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .An          (an),
    .Cath        (cath),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks frame positions j0..j1 (j = clocks since frame start). ce packs {d3,d2,d1,d0}
  // cathode patterns; lit_mask marks digits that are not blanked.
  task automatic check_slice(input string name, input int j0, input int j1,
                             input logic [31:0] ce, input logic [3:0] lit_mask,
                             input int bright);
    for (int j = j0; j <= j1; j++) begin
      int  c;
      int  d;
      bit  on;
      logic [3:0] exp_an;
      logic [7:0] exp_cath;
      @(negedge clk);
      c  = j % 16;
      d  = j / 16;
      on = lit_mask[d] && ((c / 4) < bright);
      exp_an   = on ? ~(4'b0001 << d) : 4'hF;
      exp_cath = on ? ce[d*8 +: 8] : 8'hFF;
      check($sformatf("%s an j=%0d", name, j), 32'(an), 32'(exp_an));
      check($sformatf("%s cath j=%0d", name, j), 32'(cath), 32'(exp_cath));
      check($sformatf("%s frame_start j=%0d", name, j), 32'(frame_start), 32'(j == 63));
    end
  endtask

  localparam logic [31:0] CE_1234 = 32'h9F_25_0D_99;
  localparam logic [31:0] CE_0050 = 32'hFF_FF_49_03;
  localparam logic [31:0] CE_ABCD = 32'h11_C0_63_85;

  initial begin
    rst        = 1'b1;
    value      = '0;
    dp_in      = '0;
    digit_en   = '0;
    lz_blank   = 1'b0;
    brightness = '0;
    repeat (3) @(negedge clk);
    check("reset an", 32'(an), 32'hF);
    check("reset cath", 32'(cath), 32'hFF);
    check("reset frame_start", 32'(frame_start), 32'h0);

    // Frame 0 is dark (shadows zero); inputs for frame 1 latch at its end.
    rst        = 1'b0;
    value      = 16'h1234;
    digit_en   = 4'hF;
    brightness = 2'd3;
    check_slice("f0 dark", 0, 63, CE_1234, 4'b0000, 3);

    value    = 16'h0050;
    lz_blank = 1'b1;
    check_slice("f1 1234", 0, 63, CE_1234, 4'b1111, 3);

    value      = 16'h1234;
    lz_blank   = 1'b0;
    brightness = 2'd1;
    check_slice("f2 lz 0050", 0, 63, CE_0050, 4'b0011, 3);

    brightness = 2'd0;
    check_slice("f3 bright1", 0, 63, CE_1234, 4'b1111, 1);

    brightness = 2'd3;
    check_slice("f4 bright0", 0, 63, CE_1234, 4'b1111, 0);

    // Mid-frame changes must not disturb the frame being scanned.
    check_slice("f5 pre", 0, 39, CE_1234, 4'b1111, 3);
    value = 16'hABCD;
    dp_in = 4'b0100;
    check_slice("f5 post", 40, 63, CE_1234, 4'b1111, 3);

    value    = 16'h1234;
    dp_in    = 4'b0000;
    digit_en = 4'b0101;
    check_slice("f6 abcd dp2", 0, 63, CE_ABCD, 4'b1111, 3);

    // Reset pulled mid-slot 2 while digit 2 is lit must clear outputs without a clock.
    check_slice("f7 en0101", 0, 39, CE_1234, 4'b0101, 3);
    #1 rst = 1'b1;
    #1;
    check("async reset an", 32'(an), 32'hF);
    check("async reset cath", 32'(cath), 32'hFF);
    check("async reset frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_slice("r0 dark", 0, 63, CE_1234, 4'b0000, 3);
    check_slice("r1 en0101", 0, 63, CE_1234, 4'b0101, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
